// File: rtl/floating_div_if.sv
// Load/operand/result bundle shared by the floating-point divider and its driver.
interface floating_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_load;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o_res;
    logic             o_busy;
    logic             o_done;

    modport master (output i_load, i_a, i_b, input  o_res, o_busy, o_done);
    modport slave  (input  i_load, i_a, i_b, output o_res, o_busy, o_done);
endinterface

// File: rtl/floating_div.sv
// Sequential binary32 divider: restoring radix-2 mantissa division, one quotient
// bit per clock, round-to-nearest-even with gradual underflow, fixed 28-cycle latency.
module floating_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    floating_div_if.slave  bus
);

    localparam int unsigned MW = 24;
    localparam int unsigned QW = 26;
    localparam int unsigned EW = 10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] K_NUM  = 2'd0;
    localparam logic [1:0] K_NAN  = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_ZERO = 2'd3;

    logic [2:0]             r_state, w_next;
    logic [WIDTH-1:0]       r_a, r_b, r_res;
    logic                   r_busy, r_done, r_sign;
    logic [1:0]             r_kind;
    logic signed [EW-1:0]   r_e;
    logic [MW-1:0]          r_mb;
    logic [QW-1:0]          r_rem, r_q;
    logic [4:0]             r_cnt;
    logic                   w_accept;

    assign bus.o_res  = r_res;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;

    assign w_accept = bus.i_load && ((r_state == S_IDLE) || (r_state == S_DONE));

    function automatic logic [4:0] f_lz(input logic [MW-1:0] v);
        logic found;
        f_lz  = 5'd24;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                f_lz  = 5'(MW - 1 - i);
                found = 1'b1;
            end
        end
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_UNPACK;
            S_UNPACK: w_next = S_DIV;
            S_DIV:    if (r_cnt == 5'(QW - 1)) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   if (w_accept) w_next = S_UNPACK;
            default:  w_next = S_IDLE;
        endcase
    end

    // Operand unpack: subnormals are normalised so both significands carry a leading one
    logic [MW-1:0]        w_sig_a, w_sig_b, w_m_a, w_m_b;
    logic [4:0]           w_lz_a, w_lz_b;
    logic signed [EW-1:0] w_e_a, w_e_b, w_e_q;
    logic                 w_a_max, w_b_max, w_a_fz, w_b_fz;
    logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [1:0]           w_kind;

    assign w_sig_a = {|r_a[30:23], r_a[22:0]};
    assign w_sig_b = {|r_b[30:23], r_b[22:0]};
    assign w_lz_a  = f_lz(w_sig_a);
    assign w_lz_b  = f_lz(w_sig_b);
    assign w_m_a   = w_sig_a << w_lz_a;
    assign w_m_b   = w_sig_b << w_lz_b;
    assign w_e_a   = (r_a[30:23] == 8'd0) ? (10'sd1 - $signed({5'd0, w_lz_a})) : $signed({2'd0, r_a[30:23]});
    assign w_e_b   = (r_b[30:23] == 8'd0) ? (10'sd1 - $signed({5'd0, w_lz_b})) : $signed({2'd0, r_b[30:23]});
    assign w_e_q   = w_e_a - w_e_b + 10'sd127;

    assign w_a_max  = &r_a[30:23];
    assign w_b_max  = &r_b[30:23];
    assign w_a_fz   = (r_a[22:0] == 23'd0);
    assign w_b_fz   = (r_b[22:0] == 23'd0);
    assign w_a_nan  = w_a_max & ~w_a_fz;
    assign w_b_nan  = w_b_max & ~w_b_fz;
    assign w_a_inf  = w_a_max & w_a_fz;
    assign w_b_inf  = w_b_max & w_b_fz;
    assign w_a_zero = (r_a[30:23] == 8'd0) & w_a_fz;
    assign w_b_zero = (r_b[30:23] == 8'd0) & w_b_fz;

    always_comb begin
        w_kind = K_NUM;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) w_kind = K_NAN;
        else if (w_a_inf || w_b_zero)                                             w_kind = K_INF;
        else if (w_a_zero || w_b_inf)                                             w_kind = K_ZERO;
    end

    // Restoring division step
    logic          w_qbit;
    logic [QW-1:0] w_rem_sub, w_rem_nx;

    assign w_qbit    = (r_rem >= {2'b00, r_mb});
    assign w_rem_sub = w_qbit ? (r_rem - {2'b00, r_mb}) : r_rem;
    assign w_rem_nx  = {w_rem_sub[QW-2:0], 1'b0};

    // Normalise, denormalise on underflow, round to nearest even, pack
    logic                 w_norm, w_guard, w_sticky, w_uf, w_ext_g, w_ext_s, w_inc;
    logic [MW-1:0]        w_mant, w_ext_m;
    logic signed [EW-1:0] w_e_n, w_sh_full, w_e_r;
    logic [5:0]           w_sh;
    logic [49:0]          w_wide;
    logic [MW:0]          w_mr;
    logic [22:0]          w_frac;
    logic [WIDTH-1:0]     w_res;

    assign w_norm    = r_q[QW-1];
    assign w_mant    = w_norm ? r_q[25:2] : r_q[24:1];
    assign w_guard   = w_norm ? r_q[1] : r_q[0];
    assign w_sticky  = (w_norm & r_q[0]) | (r_rem != '0);
    assign w_e_n     = w_norm ? r_e : (r_e - 10'sd1);
    assign w_uf      = (w_e_n <= 10'sd0);
    assign w_sh_full = 10'sd1 - w_e_n;
    assign w_sh      = (w_sh_full > 10'sd26) ? 6'd26 : w_sh_full[5:0];
    assign w_wide    = {w_mant, w_guard, 25'd0} >> w_sh;
    assign w_ext_m   = w_uf ? w_wide[49:26] : w_mant;
    assign w_ext_g   = w_uf ? w_wide[25] : w_guard;
    assign w_ext_s   = w_sticky | (w_uf & (|w_wide[24:0]));
    assign w_inc     = w_ext_g & (w_ext_s | w_ext_m[0]);
    assign w_mr      = {1'b0, w_ext_m} + 25'(w_inc);
    assign w_e_r     = w_mr[MW] ? (w_e_n + 10'sd1) : w_e_n;
    assign w_frac    = w_mr[MW] ? w_mr[23:1] : w_mr[22:0];

    always_comb begin
        w_res = '0;
        case (r_kind)
            K_NAN:   w_res = 32'hFFFF_FFFF;
            K_INF:   w_res = {r_sign, 8'hFF, 23'd0};
            K_ZERO:  w_res = {r_sign, 31'd0};
            default: begin
                if (w_uf)                   w_res = {r_sign, 7'd0, w_mr[23], w_mr[22:0]};
                else if (w_e_r >= 10'sd255) w_res = {r_sign, 8'hFF, 23'd0};
                else                        w_res = {r_sign, w_e_r[7:0], w_frac};
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sign <= 1'b0;
            r_kind <= K_NUM;
            r_e    <= '0;
            r_mb   <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= bus.i_a;
                r_b    <= bus.i_b;
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end
            if (r_state == S_UNPACK) begin
                r_sign <= r_a[31] ^ r_b[31];
                r_kind <= w_kind;
                r_e    <= w_e_q;
                r_mb   <= w_m_b;
                r_rem  <= {2'b00, w_m_a};
                r_q    <= '0;
                r_cnt  <= '0;
            end
            if (r_state == S_DIV) begin
                r_rem <= w_rem_nx;
                r_q   <= {r_q[QW-2:0], w_qbit};
                r_cnt <= r_cnt + 5'd1;
            end
            if (r_state == S_ROUND) begin
                r_res  <= w_res;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_floating_div.sv
// Bench for floating_div: exact rational reference quotient plus a cycle-level
// handshake reference, checked every cycle, and directed literal vectors.
module tb_floating_div;

    logic clk = 1'b0;
    logic rst_n;

    floating_div_if u_if ();

    floating_div u_dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    logic        m_busy, m_done;
    logic [31:0] m_res, m_a, m_b;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact quotient as a wide integer, then generic rounding to the nearest binary32
    function automatic logic [31:0] f_model(input logic [31:0] a, input logic [31:0] b);
        logic        s, sticky, up;
        logic [7:0]  xa, xb;
        logic [22:0] fa, fb;
        logic [95:0] ma, mb, num, q, keep, rem, half, one;
        int          ea, eb, base, p, lsb_e, sh;
        s  = a[31] ^ b[31];
        xa = a[30:23]; xb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        if ((xa == 8'hFF && fa != 0) || (xb == 8'hFF && fb != 0)) return 32'hFFFF_FFFF;
        if ((a[30:0] == 0 && b[30:0] == 0) || (a[30:0] == 31'h7F80_0000 && b[30:0] == 31'h7F80_0000))
            return 32'hFFFF_FFFF;
        if (a[30:0] == 31'h7F80_0000 || b[30:0] == 0) return {s, 8'hFF, 23'd0};
        if (a[30:0] == 0 || b[30:0] == 31'h7F80_0000) return {s, 31'd0};
        ma = (xa == 0) ? 96'(fa) : 96'({1'b1, fa});
        mb = (xb == 0) ? 96'(fb) : 96'({1'b1, fb});
        ea = (xa == 0) ? -149 : int'(xa) - 150;
        eb = (xb == 0) ? -149 : int'(xb) - 150;
        num    = ma << 60;
        q      = num / mb;
        sticky = (num % mb) != 0;
        base   = ea - eb - 60;
        p = 0;
        for (int i = 0; i < 96; i++) if (q[i]) p = i;
        lsb_e = p + base - 23;
        if (lsb_e < -149) lsb_e = -149;
        sh = lsb_e - base;
        if (sh > 95) sh = 95;
        one  = 96'd1;
        keep = q >> sh;
        half = one << (sh - 1);
        rem  = q & ((one << sh) - one);
        up   = (rem > half) || ((rem == half) && (sticky || keep[0]));
        keep = keep + 96'(up);
        if (keep[24]) begin
            keep  = keep >> 1;
            lsb_e = lsb_e + 1;
        end
        if (keep[23]) begin
            if (lsb_e + 150 >= 255) return {s, 8'hFF, 23'd0};
            return {s, 8'(lsb_e + 150), keep[22:0]};
        end
        return {s, 8'd0, keep[22:0]};
    endfunction

    // Cycle-level expectation: accept when idle, result 28 edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (!m_busy) begin
            if (u_if.i_load) begin
                m_a    <= u_if.i_a;
                m_b    <= u_if.i_b;
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_cnt  <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 27) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= f_model(m_a, m_b);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy_vs_model", 32'(u_if.o_busy), 32'(m_busy));
            chk("done_vs_model", 32'(u_if.o_done), 32'(m_done));
            chk("res_vs_model",  u_if.o_res, m_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] b);
        u_if.i_a    = a;
        u_if.i_b    = b;
        u_if.i_load = 1'b1;
        tick();
        edge_cnt    = 0;
        u_if.i_load = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp_res);
        while (u_if.o_done !== 1'b1 && edge_cnt < 60) tick();
        chk({name, " latency"}, 32'(edge_cnt), 32'd28);
        chk({name, " result"}, u_if.o_res, exp_res);
    endtask

    task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res);
        chk({name, " model"}, f_model(a, b), exp_res);
        do_load(a, b);
        wait_done(name, exp_res);
    endtask

    initial begin
        rst_n       = 1'b0;
        u_if.i_load = 1'b0;
        u_if.i_a    = '0;
        u_if.i_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset res",  u_if.o_res, 32'd0);
        chk("reset busy", 32'(u_if.o_busy), 32'd0);
        chk("reset done", 32'(u_if.o_done), 32'd0);
        rst_n = 1'b1;
        tick();

        chk("6/2 model", f_model(32'h40C0_0000, 32'h4000_0000), 32'h4040_0000);
        do_load(32'h40C0_0000, 32'h4000_0000);
        chk("6/2 busy at edge0", 32'(u_if.o_busy), 32'd1);
        chk("6/2 done at edge0", 32'(u_if.o_done), 32'd0);
        wait_done("6/2", 32'h4040_0000);

        run_case("1/3",          32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        run_case("-2/0.125",     32'hC000_0000, 32'h3E00_0000, 32'hC180_0000);
        run_case("sub tie",      32'h0000_0003, 32'h4000_0000, 32'h0000_0002);
        run_case("sub to zero",  32'h0000_0001, 32'h4080_0000, 32'h0000_0000);
        run_case("minnorm/2",    32'h0080_0000, 32'h4000_0000, 32'h0040_0000);
        run_case("1/0",          32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        run_case("0/0",          32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        run_case("-0/inf",       32'h8000_0000, 32'h7F80_0000, 32'h8000_0000);
        run_case("overflow",     32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000);
        run_case("nan/1",        32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF);
        run_case("inf/inf",      32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF);
        run_case("inf/2",        32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000);
        run_case("-3/-1",        32'hC040_0000, 32'hBF80_0000, 32'h4040_0000);
        run_case("1/sub",        32'h3F80_0000, 32'h0040_0000, 32'h7F00_0000);
        run_case("1/2^127",      32'h3F80_0000, 32'h7F00_0000, 32'h0040_0000);

        // Reload while busy is ignored; load in DONE restarts
        do_load(32'h40C0_0000, 32'h4000_0000);
        while (edge_cnt < 4) tick();
        u_if.i_a    = 32'h3F80_0000;
        u_if.i_b    = 32'h4040_0000;
        u_if.i_load = 1'b1;
        tick();
        u_if.i_load = 1'b0;
        chk("reload busy", 32'(u_if.o_busy), 32'd1);
        wait_done("ignored reload", 32'h4040_0000);
        do_load(32'h3F80_0000, 32'h4040_0000);
        chk("restart done drop", 32'(u_if.o_done), 32'd0);
        chk("restart busy", 32'(u_if.o_busy), 32'd1);
        wait_done("restart", 32'h3EAA_AAAB);

        // Asynchronous reset in the middle of an operation
        do_load(32'h40C0_0000, 32'h4000_0000);
        while (edge_cnt < 10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst res",  u_if.o_res, 32'd0);
        chk("midrst busy", 32'(u_if.o_busy), 32'd0);
        chk("midrst done", 32'(u_if.o_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_case("1/1 after reset", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
